// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared fabric-config types and chain-length constants
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ccff_state_e;

  // cbx_1__0_ segment: 9 x 6 + 2 x 2 configuration memories
  localparam int CBX_1__0_CHAIN_LEN = 58;
  localparam int DEFAULT_WORD_W     = 8;

  function automatic int rb_word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// rtl/ccff_rb_packer.sv - serial-to-parallel readback packer with flush on the last chain bit
module ccff_rb_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              sample_en,
  input  logic              sample_bit,
  input  logic              flush,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);

  localparam int PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_d;
  logic [WORD_W-1:0] data_q;
  logic [PW-1:0]     pos_q;
  logic              valid_q;

  always_comb begin
    acc_d        = acc_q;
    acc_d[pos_q] = sample_bit;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q   <= '0;
      data_q  <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        pos_q <= '0;
      end else if (sample_en) begin
        // a flushed partial word keeps its unfilled upper bits at zero
        if (flush || pos_q == PW'(WORD_W - 1)) begin
          data_q  <= acc_d;
          valid_q <= 1'b1;
          acc_q   <= '0;
          pos_q   <= '0;
        end else begin
          acc_q <= acc_d;
          pos_q <= pos_q + PW'(1);
        end
      end
    end
  end

  assign rb_valid = valid_q;
  assign rb_data  = data_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises config words into one ccff chain and packs the displaced bits
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CBX_1__0_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BW    = $clog2(WORD_W + 1);

  ccff_state_e       state_q;
  logic [WORD_W-1:0] word_q;
  logic [BW-1:0]     bits_in_word_q;
  logic [BW-1:0]     load_cnt;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  issued_d;
  logic              head_q;
  logic              shift_en_q;
  logic              issuing;
  logic              xfer;
  logic              last_sample;
  logic              enter_shift;
  int                rem;

  always_comb begin
    issuing     = (state_q == ST_SHIFT) && (bits_in_word_q != '0);
    issued_d    = issued_q + CNT_W'(issuing);
    rem         = CHAIN_LEN - int'(issued_d);
    load_cnt    = (rem >= WORD_W) ? BW'(WORD_W) : BW'(rem);
    // once every chain bit is committed no further word is taken from the source
    cfg_ready   = (state_q == ST_SHIFT) && (rem > 0) &&
                  (bits_in_word_q == '0 || (bits_in_word_q == BW'(1) && issuing));
    xfer        = cfg_valid && cfg_ready;
    last_sample = shift_en_q && (issued_q == CNT_W'(CHAIN_LEN));
    enter_shift = start && (state_q != ST_SHIFT);
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      bits_in_word_q <= '0;
      issued_q       <= '0;
      head_q         <= 1'b0;
      shift_en_q     <= 1'b0;
    end else begin
      shift_en_q <= issuing;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q        <= ST_SHIFT;
            word_q         <= '0;
            bits_in_word_q <= '0;
            issued_q       <= '0;
          end
        end
        ST_SHIFT: begin
          if (issuing) begin
            head_q   <= word_q[0];
            issued_q <= issued_d;
          end
          if (xfer) begin
            word_q         <= cfg_data;
            bits_in_word_q <= load_cnt;
          end else if (issuing) begin
            word_q         <= word_q >> 1;
            bits_in_word_q <= bits_in_word_q - BW'(1);
          end
          if (last_sample) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ccff_rb_packer #(
    .WORD_W(WORD_W)
  ) u_rb_packer (
    .clk       (prog_clk),
    .resetn    (pReset),
    .clear     (enter_shift),
    .sample_en (shift_en_q),
    .sample_bit(ccff_tail),
    .flush     (last_sample),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data)
  );

  assign ccff_head      = head_q;
  assign chain_shift_en = shift_en_q;
  assign busy           = (state_q == ST_SHIFT);
  assign done           = (state_q == ST_DONE);

endmodule
